// File: rtl/change_time_pkg.sv
// Shared types and default timing for the change_time push-button conditioner.
package change_time_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2,
    HOLD  = 2'd3
  } rpt_state_e;

  localparam int DEF_DEBOUNCE_CYC      = 1_000_000;
  localparam int DEF_REPEAT_DELAY_CYC  = 25_000_000;
  localparam int DEF_REPEAT_PERIOD_CYC = 5_000_000;
  localparam int DEF_REPEAT_GAP_CYC    = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, stable-count debouncer and
// auto-repeat FSM producing a clean active-low level with one falling edge per event.
module debounce_channel
  import change_time_pkg::*;
#(
  parameter int DEBOUNCE_CYC      = DEF_DEBOUNCE_CYC,
  parameter int REPEAT_DELAY_CYC  = DEF_REPEAT_DELAY_CYC,
  parameter int REPEAT_PERIOD_CYC = DEF_REPEAT_PERIOD_CYC,
  parameter int REPEAT_GAP_CYC    = DEF_REPEAT_GAP_CYC
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_n_raw,
  input  logic repeat_en,
  output logic btn_n_out,
  output logic pressed
);

  localparam int MAXC = max3(DEBOUNCE_CYC, REPEAT_DELAY_CYC, REPEAT_PERIOD_CYC);
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] RD_LAST   = CW'(REPEAT_DELAY_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(REPEAT_GAP_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(REPEAT_PERIOD_CYC - REPEAT_GAP_CYC - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pressed_q, pressed_d;
  rpt_state_e    state_q, state_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic          out_q, out_d;

  // Debouncer: any sample matching the current stable level restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == DB_LAST) stable_d = sync2_q;
      else                  cnt_d    = cnt_q + 1'b1;
    end
  end

  assign pressed_d = ~stable_q;

  // Repeat FSM: release always wins; every transition clears rcnt.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    if (stable_q) begin
      state_d = IDLE;
      rcnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = PRESS;
          rcnt_d  = '0;
        end
        PRESS: begin
          if (rcnt_q == RD_LAST) begin
            if (repeat_en) begin
              state_d = GAP;
              rcnt_d  = '0;
            end
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        GAP: begin
          if (rcnt_q == GAP_LAST) begin
            state_d = repeat_en ? HOLD : PRESS;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        HOLD: begin
          if (!repeat_en) begin
            state_d = PRESS;
            rcnt_d  = '0;
          end else if (rcnt_q == HOLD_LAST) begin
            state_d = GAP;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          rcnt_d  = '0;
        end
      endcase
    end
  end

  assign out_d = (state_d == IDLE) || (state_d == GAP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      stable_q  <= 1'b1;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
      state_q   <= IDLE;
      rcnt_q    <= '0;
      out_q     <= 1'b1;
    end else begin
      sync1_q   <= btn_n_raw;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
      out_q     <= out_d;
    end
  end

  assign btn_n_out = out_q;
  assign pressed   = pressed_q;

endmodule

// File: rtl/change_time_debounce.sv
// Conditions N raw active-low time-set buttons into clean levels for the
// change_time PIO; channels are independent copies of debounce_channel.
module change_time_debounce
  import change_time_pkg::*;
#(
  parameter int N                 = 2,
  parameter int DEBOUNCE_CYC      = DEF_DEBOUNCE_CYC,
  parameter int REPEAT_DELAY_CYC  = DEF_REPEAT_DELAY_CYC,
  parameter int REPEAT_PERIOD_CYC = DEF_REPEAT_PERIOD_CYC,
  parameter int REPEAT_GAP_CYC    = DEF_REPEAT_GAP_CYC
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] btn_n_raw,
  input  logic [N-1:0] repeat_en,
  output logic [N-1:0] btn_n_out,
  output logic [N-1:0] pressed
);

  // A gap shorter than 2 cycles would be missed by the PIO's two-stage sampler.
  if (REPEAT_GAP_CYC < 2 || REPEAT_GAP_CYC >= REPEAT_PERIOD_CYC) begin : g_param_err
    $error("change_time_debounce: REPEAT_GAP_CYC must be in [2, REPEAT_PERIOD_CYC-1]");
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYC      (DEBOUNCE_CYC),
      .REPEAT_DELAY_CYC  (REPEAT_DELAY_CYC),
      .REPEAT_PERIOD_CYC (REPEAT_PERIOD_CYC),
      .REPEAT_GAP_CYC    (REPEAT_GAP_CYC)
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .btn_n_raw (btn_n_raw[i]),
      .repeat_en (repeat_en[i]),
      .btn_n_out (btn_n_out[i]),
      .pressed   (pressed[i])
    );
  end

endmodule

// File: tb/tb_change_time_debounce.sv
// Directed bench for change_time_debounce with short timing parameters.
module tb_change_time_debounce;

  localparam int N  = 2;
  localparam int DB = 8;
  localparam int RD = 40;
  localparam int RP = 20;
  localparam int RG = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] btn_n_raw;
  logic [N-1:0] repeat_en;
  logic [N-1:0] btn_n_out;
  logic [N-1:0] pressed;

  always #5 clk = ~clk;

  change_time_debounce #(
    .N                 (N),
    .DEBOUNCE_CYC      (DB),
    .REPEAT_DELAY_CYC  (RD),
    .REPEAT_PERIOD_CYC (RP),
    .REPEAT_GAP_CYC    (RG)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn_n_raw (btn_n_raw),
    .repeat_en (repeat_en),
    .btn_n_out (btn_n_out),
    .pressed   (pressed)
  );

  typedef struct {
    logic [1:0] raw;
    logic [1:0] ren;
    int         cycles;
    logic [1:0] exp_out;
    logic [1:0] exp_prs;
  } vec_t;

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  logic [1:0] prev_out;
  int         falls0[$];
  int         rises0[$];
  int         falls1 = 0;

  task automatic check_v(input string name, input logic [1:0] act, input logic [1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample 1 ns after the edge and log output edges by cycle.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (prev_out[0] && !btn_n_out[0]) falls0.push_back(cyc);
    if (!prev_out[0] && btn_n_out[0]) rises0.push_back(cyc);
    if (prev_out[1] && !btn_n_out[1]) falls1++;
    prev_out = btn_n_out;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    vec_t vecs[10];
    int   c0, a, a2, errs;
    int   exp_f[5];

    vecs[0] = '{2'b10, 2'b00, 10, 2'b11, 2'b00};
    vecs[1] = '{2'b10, 2'b00,  1, 2'b10, 2'b01};
    vecs[2] = '{2'b10, 2'b00, 89, 2'b10, 2'b01};
    vecs[3] = '{2'b11, 2'b00, 10, 2'b10, 2'b01};
    vecs[4] = '{2'b11, 2'b00,  1, 2'b11, 2'b00};
    vecs[5] = '{2'b11, 2'b00, 12, 2'b11, 2'b00};
    vecs[6] = '{2'b00, 2'b00, 10, 2'b11, 2'b00};
    vecs[7] = '{2'b00, 2'b00,  1, 2'b00, 2'b11};
    vecs[8] = '{2'b10, 2'b00, 11, 2'b10, 2'b01};
    vecs[9] = '{2'b11, 2'b00, 11, 2'b11, 2'b00};
    exp_f   = '{0, 44, 64, 84, 104};

    reset_n   = 1'b0;
    btn_n_raw = 2'b11;
    repeat_en = 2'b00;
    prev_out  = 2'b11;
    run(2);
    check_v("reset_out", btn_n_out, 2'b11);
    check_v("reset_pressed", pressed, 2'b00);
    reset_n = 1'b1;
    run(3);

    // Clean presses/releases, single and simultaneous channels.
    falls0.delete();
    falls1 = 0;
    c0 = cyc;
    for (int i = 0; i < 10; i++) begin
      btn_n_raw = vecs[i].raw;
      repeat_en = vecs[i].ren;
      run(vecs[i].cycles);
      check_v($sformatf("vec%0d_out", i), btn_n_out, vecs[i].exp_out);
      check_v($sformatf("vec%0d_pressed", i), pressed, vecs[i].exp_prs);
      if (i == 5) begin
        check_i("clean_fall_count", falls0.size(), 1);
        check_i("clean_fall_cycle", falls0[0], c0 + 11);
        check_i("clean_ch1_falls", falls1, 0);
      end
    end

    // Bounce every 3 cycles for 30 cycles, then settle low.
    falls0.delete();
    errs = 0;
    for (int seg = 0; seg < 10; seg++) begin
      btn_n_raw = (seg % 2 == 0) ? 2'b10 : 2'b11;
      for (int k = 0; k < 3; k++) begin
        step();
        if (btn_n_out !== 2'b11) errs++;
      end
    end
    check_i("bounce_glitches", errs, 0);
    btn_n_raw = 2'b10;
    run(10);
    check_v("bounce_settle_10", btn_n_out, 2'b11);
    step();
    check_v("bounce_settle_11", btn_n_out, 2'b10);
    check_i("bounce_fall_count", falls0.size(), 1);
    btn_n_raw = 2'b11;
    run(12);
    check_v("bounce_release", btn_n_out, 2'b11);

    // Auto-repeat while held, then release timed to land inside a GAP.
    falls0.delete();
    rises0.delete();
    repeat_en = 2'b01;
    btn_n_raw = 2'b10;
    run(11);
    a = cyc;
    check_v("rep_accept", btn_n_out, 2'b10);
    run(111);
    check_i("rep_fall_count", falls0.size(), 5);
    for (int k = 0; k < 5; k++)
      check_i($sformatf("rep_fall%0d", k), falls0[k] - a, exp_f[k]);
    for (int k = 0; k < 4; k++)
      check_i($sformatf("rep_gap%0d", k), falls0[k+1] - rises0[k], RG);
    btn_n_raw = 2'b11;
    run(9);
    check_v("gap_rel_out", btn_n_out, 2'b11);
    step();
    check_v("gap_rel_prs_10", pressed, 2'b01);
    step();
    check_v("gap_rel_prs_11", pressed, 2'b00);
    run(20);
    check_i("gap_rel_no_fall", falls0.size(), 5);
    check_v("gap_rel_idle", btn_n_out, 2'b11);

    // repeat_en dropped during HOLD parks the channel in PRESS.
    falls0.delete();
    rises0.delete();
    btn_n_raw = 2'b10;
    run(11);
    a2 = cyc;
    check_v("hold_accept", btn_n_out, 2'b10);
    run(50);
    repeat_en = 2'b00;
    run(45);
    check_i("hold_drop_falls", falls0.size(), 2);
    check_i("hold_drop_rises", rises0.size(), 1);
    check_v("hold_drop_out", btn_n_out, 2'b10);
    repeat_en = 2'b01;
    step();
    check_i("hold_reen_cycle", cyc - a2, 96);
    check_v("hold_reen_gap", btn_n_out, 2'b11);
    run(3);
    check_v("hold_reen_gap_end", btn_n_out, 2'b11);
    step();
    check_v("hold_reen_fall", btn_n_out, 2'b10);
    btn_n_raw = 2'b11;
    repeat_en = 2'b00;
    run(12);
    check_v("hold_release", btn_n_out, 2'b11);

    // Asynchronous reset while both buttons are held.
    btn_n_raw = 2'b00;
    run(11);
    check_v("rst_pre_out", btn_n_out, 2'b00);
    #3;
    reset_n = 1'b0;
    #1;
    check_v("rst_async_out", btn_n_out, 2'b11);
    check_v("rst_async_prs", pressed, 2'b00);
    run(2);
    reset_n  = 1'b1;
    prev_out = btn_n_out;
    run(10);
    check_v("rst_reaccept_10", btn_n_out, 2'b11);
    step();
    check_v("rst_reaccept_11", btn_n_out, 2'b00);
    check_v("rst_reaccept_prs", pressed, 2'b11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
